// File: rtl/mix.sv
`default_nettype none
// ============================================================================
// mix : registered AES ShiftRows / InvShiftRows stage, 1-cycle latency
// Rev 1.0
// ============================================================================
module mix #(
   parameter int DATA_WIDTH = 128,
   parameter bit INVERSE    = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  shiftRow_valid_in,
   input  logic [DATA_WIDTH-1:0] shiftRow_data_in,
   output logic [DATA_WIDTH-1:0] shiftRow_data_out,
   output logic                  shiftRow_valid_out
);

   logic [DATA_WIDTH-1:0] w_shifted;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   if (DATA_WIDTH != 128) begin : g_bad_width
      $error("mix: DATA_WIDTH must be 128");
   end

   // Byte b[4c+r] is s[r][c]; each output byte copies one input byte of the same row.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         localparam int c_SRC_COL = INVERSE ? ((c - r + 4) % 4) : ((c + r) % 4);
         assign w_shifted[127-8*(4*c+r) -: 8] = shiftRow_data_in[127-8*(4*c_SRC_COL+r) -: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= shiftRow_valid_in;
         if (shiftRow_valid_in) begin
            r_data <= w_shifted;
         end
      end
   end

   assign shiftRow_data_out  = r_data;
   assign shiftRow_valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mix.sv
`default_nettype none
// ============================================================================
// tb_mix : scoreboard bench for forward and inverse ShiftRows instances
// Rev 1.0
// ============================================================================
module tb_mix;

   logic         clk = 1'b0;
   logic         rst;
   logic         vin;
   logic [127:0] din;
   logic [127:0] o_df, o_di;
   logic         o_vf, o_vi;

   int errors = 0;
   int checks = 0;

   logic [127:0] qf[$];
   logic [127:0] qi[$];
   logic [127:0] lastf = '0;
   logic [127:0] lasti = '0;

   mix #(.DATA_WIDTH(128), .INVERSE(1'b0)) u_fwd (
      .clk(clk), .rst(rst), .shiftRow_valid_in(vin), .shiftRow_data_in(din),
      .shiftRow_data_out(o_df), .shiftRow_valid_out(o_vf));

   mix #(.DATA_WIDTH(128), .INVERSE(1'b1)) u_inv (
      .clk(clk), .rst(rst), .shiftRow_valid_in(vin), .shiftRow_data_in(din),
      .shiftRow_data_out(o_di), .shiftRow_valid_out(o_vi));

   always #5 clk = ~clk;

   // Reference: view the state as a 4x4 byte matrix and rotate each row.
   function automatic logic [127:0] model(input logic [127:0] d, input bit inv);
      logic [7:0]   s [4][4];
      logic [127:0] o;
      int           rot;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = d[127-8*(4*c+r) -: 8];
      o = '0;
      for (int r = 0; r < 4; r++) begin
         rot = inv ? (4 - r) % 4 : r;
         for (int c = 0; c < 4; c++)
            o[127-8*(4*c+r) -: 8] = s[r][(c + rot) % 4];
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Expected results enter the scoreboard when a valid input is accepted.
   always @(posedge clk) begin
      if (rst && vin) begin
         qf.push_back(model(din, 1'b0));
         qi.push_back(model(din, 1'b1));
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         qf.delete();
         qi.delete();
         lastf = '0;
         lasti = '0;
         chk("rst_fwd_data",  o_df, 128'h0);
         chk("rst_fwd_valid", {127'h0, o_vf}, 128'h0);
         chk("rst_inv_data",  o_di, 128'h0);
         chk("rst_inv_valid", {127'h0, o_vi}, 128'h0);
      end else begin
         if (qf.size() > 0) begin
            lastf = qf.pop_front();
            chk("fwd_valid", {127'h0, o_vf}, 128'h1);
            chk("fwd_data", o_df, lastf);
         end else begin
            chk("fwd_idle_valid", {127'h0, o_vf}, 128'h0);
            chk("fwd_hold_data", o_df, lastf);
         end
         if (qi.size() > 0) begin
            lasti = qi.pop_front();
            chk("inv_valid", {127'h0, o_vi}, 128'h1);
            chk("inv_data", o_di, lasti);
         end else begin
            chk("inv_idle_valid", {127'h0, o_vi}, 128'h0);
            chk("inv_hold_data", o_di, lasti);
         end
      end
   end

   task automatic drive(input logic v, input logic [127:0] d);
      @(posedge clk);
      #1;
      vin = v;
      din = d;
   endtask

   initial begin
      rst = 1'b0;
      vin = 1'b0;
      din = rnd128();
      for (int i = 0; i < 4; i++) drive(logic'($urandom_range(0, 1)), rnd128());
      drive(1'b0, rnd128());
      rst = 1'b1;

      // Known-answer vectors
      drive(1'b1, 128'h4915598f55e5d7a0daca94fa1f0a63f7);
      drive(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
      chk("kat_fwd_aes", o_df, 128'h49e594f755ca638fda0a59a01f15d7fa);
      drive(1'b1, 128'h00050a0f04090e03080d02070c01060b);
      chk("kat_fwd_idx", o_df, 128'h00050a0f04090e03080d02070c01060b);
      drive(1'b1, 128'h49e594f755ca638fda0a59a01f15d7fa);
      chk("kat_inv_idx", o_di, 128'h000102030405060708090a0b0c0d0e0f);
      drive(1'b0, rnd128());
      chk("kat_inv_aes", o_di, 128'h4915598f55e5d7a0daca94fa1f0a63f7);

      // Valid gating: output holds the last transformed state
      for (int i = 0; i < 3; i++) drive(1'b0, rnd128());
      chk("gate_valid_low", {127'h0, o_vf}, 128'h0);
      chk("gate_hold", o_df, model(128'h49e594f755ca638fda0a59a01f15d7fa, 1'b0));

      // Back-to-back random stream
      for (int i = 0; i < 8; i++) drive(1'b1, rnd128());

      // Asynchronous reset between edges, mid-stream
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_fwd", {o_vf, o_df}, 129'h0);
      chk("async_rst_inv", {o_vi, o_di}, 129'h0);
      for (int i = 0; i < 2; i++) drive(1'b1, rnd128());
      rst = 1'b1;
      vin = 1'b0;
      drive(1'b0, rnd128());
      drive(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
      drive(1'b0, rnd128());
      chk("post_rst_first", o_df, 128'h00050a0f04090e03080d02070c01060b);

      // Random mix of valid and idle cycles
      for (int i = 0; i < 40; i++) drive(logic'($urandom_range(0, 1)), rnd128());
      drive(1'b0, rnd128());
      drive(1'b0, rnd128());
      @(posedge clk);
      #1;
      chk("scoreboard_drained", 128'(qf.size() + qi.size()), 128'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mix.md
Name: mix

Overview:
- Registered AES ShiftRows stage on one 128-bit state.
- Sits directly upstream of the combined SubByte/MixColumn stage in the round datapath.
- Byte ordering is AES column-major: byte b[i] occupies bits [127-8i -: 8], and state element s[r][c] = b[4c+r].
  - Column 0 is bits [127:96]; row 0 of each column is that column's most-significant byte.
- Valid travels alongside the data with fixed one-cycle latency; there is no backpressure.

Parameters:
- DATA_WIDTH, 128, state width; only 128 is supported. Any other value is an elaboration error.
- INVERSE, 0, 0 = forward ShiftRows (encrypt); 1 = InvShiftRows (decrypt).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- shiftRow_valid_in  input  1  high when shiftRow_data_in holds a valid state.
- shiftRow_data_in  input  DATA_WIDTH  state to be row-shifted.
- shiftRow_data_out  output  DATA_WIDTH  registered row-shifted state.
- shiftRow_valid_out  output  1  registered valid accompanying shiftRow_data_out.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, named rst.
- Reset: on rst low, immediately (no clock needed) shiftRow_data_out = 128'h0 and shiftRow_valid_out = 0. Both hold these values while rst is low.
- Forward transform (INVERSE=0): out s[r][c] = in s[r][(c+r) mod 4].
  - Row 0 unchanged; row 1 rotated left 1; row 2 rotated left 2; row 3 rotated left 3.
- Inverse transform (INVERSE=1): out s[r][c] = in s[r][(c-r) mod 4].
  - Row 0 unchanged; row 1 rotated right 1; row 2 rotated right 2; row 3 rotated right 3.
- The transform is pure wiring (byte permutation) with no arithmetic. Each output byte is an exact copy of exactly one input byte.
- Latency is exactly 1 clock. Every rising edge with rst high:
  - shiftRow_valid_out <= shiftRow_valid_in.
  - If shiftRow_valid_in = 1: shiftRow_data_out <= transform(shiftRow_data_in).
  - If shiftRow_valid_in = 0: shiftRow_data_out holds its previous value.
- Throughput is one state per cycle. Back-to-back valid inputs produce back-to-back valid outputs in the same order.
- No handshake or stall: the consumer must accept every cycle in which shiftRow_valid_out = 1.
- Reset asserted mid-stream: the in-flight state is discarded and outputs go to zero at once.
  - After rst deasserts, the first valid output appears one edge after the first valid input.
- Forward followed by inverse (or the reverse order) is the identity.
- No X propagation from an idle input: when valid_in = 0, the data input is ignored.

Test Plan:
- Reset: hold rst=0 with random inputs and toggling clk -> data_out = 0 and valid_out = 0. Assert rst asynchronously between edges -> outputs clear before the next edge.
- Forward vector (INVERSE=0): valid_in=1, data_in=4915598f55e5d7a0daca94fa1f0a63f7 -> one edge later valid_out=1, data_out=49e594f755ca638fda0a59a01f15d7fa.
- Forward index vector: data_in=000102030405060708090a0b0c0d0e0f -> data_out=00050a0f04090e03080d02070c01060b after 1 cycle.
- Inverse (INVERSE=1): data_in=00050a0f04090e03080d02070c01060b -> data_out=000102030405060708090a0b0c0d0e0f. Also data_in=49e594f755ca638fda0a59a01f15d7fa -> data_out=4915598f55e5d7a0daca94fa1f0a63f7.
- Valid gating: drive a valid state, then valid_in=0 with different data for 3 cycles -> valid_out falls one cycle after valid_in, and data_out holds the last transformed state.
- Streaming plus reset: 8 back-to-back random valid states checked against a software model at exactly 1-cycle latency. Pulse rst low mid-stream -> outputs zero during reset, then correct results resume one cycle after the next valid input.
